// File: rtl/bg_pkg.sv
// Shared types and constants for the background arbiter/mixer slice.
package bg_pkg;

    localparam int unsigned PIX_W = 8;

    // One layer pixel: colour bank in the top nibble, pen in the bottom nibble.
    typedef struct packed {
        logic [3:0] col;
        logic [3:0] pen;
    } pix_t;

    typedef enum logic [0:0] {
        ARB_IDLE,
        ARB_WAIT
    } arb_state_t;

endpackage

// File: rtl/bg_rr_arbiter.sv
// Round-robin pending-layer selector: combinational grant, registered rotate pointer.
module bg_rr_arbiter #(
    parameter int unsigned NUM_LAYERS = 3,
    parameter int unsigned IDX_W      = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NUM_LAYERS-1:0] pending,
    input  logic                  advance,
    input  logic [IDX_W-1:0]      done_idx,
    output logic                  grant_valid,
    output logic [IDX_W-1:0]      grant_idx
);

    logic [IDX_W-1:0] rr_ptr;

    function automatic logic [IDX_W-1:0] wrap_idx(input int unsigned v);
        int unsigned w;
        w = (v >= NUM_LAYERS) ? v - NUM_LAYERS : v;
        return IDX_W'(w);
    endfunction

    // Scan downward so the closest pending layer at or after rr_ptr wins last.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        for (int k = NUM_LAYERS - 1; k >= 0; k--) begin
            if (pending[wrap_idx(int'(rr_ptr) + k)]) begin
                grant_valid = 1'b1;
                grant_idx   = wrap_idx(int'(rr_ptr) + k);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr <= '0;
        end else if (advance) begin
            rr_ptr <= wrap_idx(int'(done_idx) + 1);
        end
    end

endmodule

// File: rtl/board_bg_arbiter_mixer.sv
// N-layer background back end: shared SDRAM port arbitration plus 2-stage pixel mixer.
module board_bg_arbiter_mixer
    import bg_pkg::*;
#(
    parameter int unsigned NUM_LAYERS = 3,
    parameter int unsigned ADDR_W     = 21,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned REGION_W   = 4,
    localparam int unsigned IDX_W     = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1
) (
    input  logic                           CLK_32M,
    input  logic                           reset_n,
    input  logic                           CE_PIX,
    input  logic [NUM_LAYERS-1:0]          layer_req,
    input  logic [NUM_LAYERS*ADDR_W-1:0]   layer_addr,
    input  logic [NUM_LAYERS*REGION_W-1:0] layer_base,
    output logic [NUM_LAYERS-1:0]          layer_ack,
    output logic [DATA_W-1:0]              layer_data,
    output logic                           sdr_req,
    output logic [ADDR_W+REGION_W-1:0]     sdr_addr,
    input  logic                           sdr_ack,
    input  logic [DATA_W-1:0]              sdr_data,
    input  logic [NUM_LAYERS-1:0]          layer_en,
    input  logic [NUM_LAYERS*PIX_W-1:0]    layer_pix,
    input  logic [NUM_LAYERS-1:0]          layer_cp15,
    input  logic [NUM_LAYERS-1:0]          layer_cp8,
    output logic [PIX_W-1:0]               mix_pix,
    output logic [IDX_W-1:0]               mix_layer,
    output logic                           mix_opaque,
    output logic                           P1L
);

    arb_state_t           state;
    logic [IDX_W-1:0]     gnt_q;
    logic [NUM_LAYERS-1:0] pending;
    logic                 grant_valid;
    logic [IDX_W-1:0]     grant_idx;
    logic                 xfer_done;
    logic [ADDR_W-1:0]    addr_arr [NUM_LAYERS];
    logic [REGION_W-1:0]  base_arr [NUM_LAYERS];

    for (genvar i = 0; i < NUM_LAYERS; i++) begin : g_unpack_req
        assign addr_arr[i] = layer_addr[i*ADDR_W +: ADDR_W];
        assign base_arr[i] = layer_base[i*REGION_W +: REGION_W];
    end

    assign pending   = layer_req ^ layer_ack;
    assign xfer_done = (state == ARB_WAIT) && (sdr_ack == sdr_req);

    bg_rr_arbiter #(
        .NUM_LAYERS (NUM_LAYERS),
        .IDX_W      (IDX_W)
    ) u_rr_arbiter (
        .clk         (CLK_32M),
        .rst_n       (reset_n),
        .pending     (pending),
        .advance     (xfer_done),
        .done_idx    (gnt_q),
        .grant_valid (grant_valid),
        .grant_idx   (grant_idx)
    );

    // Address and base are captured at grant; later changes don't disturb the transfer.
    always_ff @(posedge CLK_32M or negedge reset_n) begin
        if (!reset_n) begin
            state      <= ARB_IDLE;
            gnt_q      <= '0;
            sdr_req    <= 1'b0;
            sdr_addr   <= '0;
            layer_ack  <= '0;
            layer_data <= '0;
        end else begin
            unique case (state)
                ARB_IDLE: begin
                    if (grant_valid) begin
                        sdr_addr <= {base_arr[grant_idx], addr_arr[grant_idx]};
                        sdr_req  <= ~sdr_req;
                        gnt_q    <= grant_idx;
                        state    <= ARB_WAIT;
                    end
                end
                ARB_WAIT: begin
                    if (sdr_ack == sdr_req) begin
                        layer_data       <= sdr_data;
                        layer_ack[gnt_q] <= ~layer_ack[gnt_q];
                        state            <= ARB_IDLE;
                    end
                end
                default: state <= ARB_IDLE;
            endcase
        end
    end

    logic [NUM_LAYERS*PIX_W-1:0] pix_s1_q;
    logic [NUM_LAYERS-1:0]       cp15_s1_q;
    logic [NUM_LAYERS-1:0]       cp8_s1_q;
    logic [NUM_LAYERS-1:0]       en_s1_q;
    pix_t                        pix_s1 [NUM_LAYERS];
    logic [NUM_LAYERS-1:0]       opaque;
    logic [NUM_LAYERS-1:0]       pen3;
    pix_t                        mix_pix_d;
    logic [IDX_W-1:0]            mix_layer_d;
    logic                        p1l_d;

    for (genvar i = 0; i < NUM_LAYERS; i++) begin : g_unpack_pix
        assign pix_s1[i] = pix_t'(pix_s1_q[i*PIX_W +: PIX_W]);
        assign opaque[i] = en_s1_q[i] & (pix_s1[i].pen != 4'd0);
        assign pen3[i]   = pix_s1[i].pen[3];
    end

    // Back-most layer's pen is the backdrop when nothing is opaque.
    always_comb begin
        mix_pix_d   = pix_s1[NUM_LAYERS-1];
        mix_layer_d = IDX_W'(NUM_LAYERS - 1);
        for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
            if (opaque[i]) begin
                mix_pix_d   = pix_s1[i];
                mix_layer_d = IDX_W'(i);
            end
        end
    end

    assign p1l_d = ~|(cp15_s1_q & opaque) & ~|(cp8_s1_q & en_s1_q & pen3);

    always_ff @(posedge CLK_32M or negedge reset_n) begin
        if (!reset_n) begin
            pix_s1_q   <= '0;
            cp15_s1_q  <= '0;
            cp8_s1_q   <= '0;
            en_s1_q    <= '0;
            mix_pix    <= '0;
            mix_layer  <= '0;
            mix_opaque <= 1'b0;
            P1L        <= 1'b1;
        end else if (CE_PIX) begin
            pix_s1_q   <= layer_pix;
            cp15_s1_q  <= layer_cp15;
            cp8_s1_q   <= layer_cp8;
            en_s1_q    <= layer_en;
            mix_pix    <= mix_pix_d;
            mix_layer  <= mix_layer_d;
            mix_opaque <= |opaque;
            P1L        <= p1l_d;
        end
    end

endmodule
